pipelined_addressed_mux: RTL and testbench

PIPELINED_ADDRESSED_MUX -- requirements
Module: pipelined_addressed_mux

---
 rtl/pipelined_addressed_mux_pkg.sv | 14 +
 rtl/pipeline_stage_rv.sv | 31 +++
 rtl/pipelined_addressed_mux.sv | 65 ++++++
 tb/tb_pipelined_addressed_mux.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addressed_mux_pkg.sv
// Shared constants and helpers for the pipelined addressed multiplexer.
package pipelined_addressed_mux_pkg;

  localparam int DEFAULT_WORD_WIDTH  = 32;
  localparam int DEFAULT_ADDR_WIDTH  = 3;
  localparam int DEFAULT_INPUT_COUNT = 8;
  localparam int DEFAULT_PIPE_DEPTH  = 2;

  // True when the address points at an existing input word.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned count);
    return addr < count;
  endfunction

endpackage

// File: rtl/pipeline_stage_rv.sv
// One valid/ready register stage; accepts whenever empty or when its
// current contents leave downstream in the same cycle.
module pipeline_stage_rv #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Data only changes on a real load, so idle inputs never disturb held contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipelined_addressed_mux.sv
// Addressed word selector followed by a chain of valid/ready register stages.
module pipelined_addressed_mux
  import pipelined_addressed_mux_pkg::*;
#(
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INPUT_COUNT = DEFAULT_INPUT_COUNT,
  parameter int PIPE_DEPTH  = DEFAULT_PIPE_DEPTH
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [WORD_WIDTH*INPUT_COUNT-1:0] data_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_WIDTH-1:0]             data_out,
  output logic                              addr_err
);

  logic [WORD_WIDTH-1:0] sel_word;
  logic                  sel_err;

  logic                  stage_valid [PIPE_DEPTH+1];
  logic                  stage_ready [PIPE_DEPTH+1];
  logic [WORD_WIDTH:0]   stage_data  [PIPE_DEPTH+1];

  // Out-of-range addresses match no input word and fall through to zero.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      if (addr == ADDR_WIDTH'(k)) begin
        sel_word = data_in[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign sel_err = !addr_in_range(32'(addr), INPUT_COUNT);

  assign stage_valid[0]          = in_valid;
  assign stage_data[0]           = {sel_err, sel_word};
  assign in_ready                = stage_ready[0];
  assign stage_ready[PIPE_DEPTH] = out_ready;

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
    pipeline_stage_rv #(
      .WIDTH(WORD_WIDTH + 1)
    ) u_stage (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_valid (stage_valid[i]),
      .in_ready (stage_ready[i]),
      .in_data  (stage_data[i]),
      .out_valid(stage_valid[i+1]),
      .out_ready(stage_ready[i+1]),
      .out_data (stage_data[i+1])
    );
  end

  assign out_valid = stage_valid[PIPE_DEPTH];
  assign data_out  = stage_data[PIPE_DEPTH][WORD_WIDTH-1:0];
  assign addr_err  = stage_data[PIPE_DEPTH][WORD_WIDTH];

endmodule

// File: tb/tb_pipelined_addressed_mux.sv
// Self-checking bench: a default instance and a 6-input instance, directed
// vectors plus a random run scored against a queue model.
module tb_pipelined_addressed_mux;

  localparam int W     = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 2;
  localparam int N6    = 6;

  logic            clock;
  logic            reset_n;

  logic            in_valid, in_ready, out_valid, out_ready, addr_err;
  logic [AW-1:0]   addr;
  logic [W*8-1:0]  data_in;
  logic [W-1:0]    data_out;

  logic            in_valid6, in_ready6, out_valid6, out_ready6, addr_err6;
  logic [AW-1:0]   addr6;
  logic [W*N6-1:0] data_in6;
  logic [W-1:0]    data_out6;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  exp_word8;
    logic          exp_err8;
    logic [W-1:0]  exp_word6;
    logic          exp_err6;
  } vec_t;

  typedef struct {
    logic          vld;
    logic [AW-1:0] a;
    logic          ordy;
    logic          exp_ir;
    logic          exp_ov;
    logic [W-1:0]  exp_data;
  } step_t;

  vec_t  vecs [8];
  step_t steps [12];

  pipelined_addressed_mux dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .addr(addr), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .addr_err(addr_err)
  );

  pipelined_addressed_mux #(.INPUT_COUNT(N6)) dut6 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid6), .in_ready(in_ready6), .addr(addr6), .data_in(data_in6),
    .out_valid(out_valid6), .out_ready(out_ready6), .data_out(data_out6), .addr_err(addr_err6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [AW-1:0] a, input logic ordy);
    in_valid  = vld;
    addr      = a;
    out_ready = ordy;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Reference selection: word at the address, or zero with error when out of range.
  function automatic logic [W:0] refSelect6(input logic [AW-1:0] a, input logic [W*N6-1:0] bus);
    logic [W*N6-1:0] shifted;
    if (int'(a) >= N6) return {1'b1, {W{1'b0}}};
    shifted = bus >> (int'(a) * W);
    return {1'b0, shifted[W-1:0]};
  endfunction

  initial begin
    logic [W:0] exp_q [$];
    logic [W:0] exp_item;
    logic [W-1:0] got_data [$];
    int got_cyc [$];
    int n_out;
    logic [W-1:0] last_out;

    for (int i = 0; i < 8; i++) begin
      vecs[i].addr      = 3'(i);
      vecs[i].exp_word8 = 32'h10 + 32'(i);
      vecs[i].exp_err8  = 1'b0;
    end
    vecs[0].exp_word6 = 32'h20; vecs[0].exp_err6 = 1'b0;
    vecs[1].exp_word6 = 32'h21; vecs[1].exp_err6 = 1'b0;
    vecs[2].exp_word6 = 32'h22; vecs[2].exp_err6 = 1'b0;
    vecs[3].exp_word6 = 32'h23; vecs[3].exp_err6 = 1'b0;
    vecs[4].exp_word6 = 32'h24; vecs[4].exp_err6 = 1'b0;
    vecs[5].exp_word6 = 32'h25; vecs[5].exp_err6 = 1'b0;
    vecs[6].exp_word6 = 32'h0;  vecs[6].exp_err6 = 1'b1;
    vecs[7].exp_word6 = 32'h0;  vecs[7].exp_err6 = 1'b1;

    steps[0]  = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h0};
    steps[1]  = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0};
    steps[2]  = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 32'h11};
    steps[3]  = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 32'h11};
    steps[4]  = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 32'h11};
    steps[5]  = '{1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 32'h12};
    steps[6]  = '{1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 32'h13};
    steps[7]  = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 32'h14};
    steps[8]  = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 32'h15};
    steps[9]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 32'h15};
    steps[10] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 32'h16};
    steps[11] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0};

    for (int k = 0; k < 8; k++) data_in[k*W +: W] = 32'h10 + 32'(k);
    for (int k = 0; k < N6; k++) data_in6[k*W +: W] = 32'h20 + 32'(k);
    applyStimulus(1'b0, '0, 1'b1);
    in_valid6 = 1'b0; addr6 = '0; out_ready6 = 1'b1;
    reset_n = 1'b0;

    #2;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_data_out", data_out, 32'h0);
    checkOutput("reset_addr_err", addr_err, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset6_out_valid", out_valid6, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", in_ready, 1'b1);
    checkOutput("post_reset_out_valid", out_valid, 1'b0);

    // Single words: captured at edge N, presented to downstream at edge N+DEPTH.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].addr, 1'b1);
      in_valid6 = 1'b1; addr6 = vecs[i].addr;
      nextCycle();
      in_valid = 1'b0; in_valid6 = 1'b0;
      checkOutput("latency_early_valid", out_valid, 1'b0);
      nextCycle();
      checkOutput("vec_out_valid", out_valid, 1'b1);
      checkOutput("vec_data_out", data_out, vecs[i].exp_word8);
      checkOutput("vec_addr_err", addr_err, vecs[i].exp_err8);
      checkOutput("vec6_out_valid", out_valid6, 1'b1);
      checkOutput("vec6_data_out", data_out6, vecs[i].exp_word6);
      checkOutput("vec6_addr_err", addr_err6, vecs[i].exp_err6);
      nextCycle();
      checkOutput("vec_no_duplicate", out_valid, 1'b0);
    end

    // Back-to-back streaming with no backpressure.
    got_data.delete(); got_cyc.delete();
    for (int c = 0; c < 14; c++) begin
      if (c < 8) applyStimulus(1'b1, 3'(c), 1'b1);
      else applyStimulus(1'b0, '0, 1'b1);
      #1;
      if (c < 8) checkOutput("stream_in_ready", in_ready, 1'b1);
      if (out_valid) begin
        got_data.push_back(data_out);
        got_cyc.push_back(c);
      end
      nextCycle();
    end
    checkOutput("stream_count", 64'(got_data.size()), 64'd8);
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      checkOutput("stream_order", got_data[i], 32'h10 + 32'(i));
      checkOutput("stream_consecutive", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
    end

    // Backpressure fill, full-pipeline shifting, then drain.
    for (int s = 0; s < 12; s++) begin
      applyStimulus(steps[s].vld, steps[s].a, steps[s].ordy);
      #1;
      checkOutput($sformatf("bp_in_ready_%0d", s), in_ready, steps[s].exp_ir);
      checkOutput($sformatf("bp_out_valid_%0d", s), out_valid, steps[s].exp_ov);
      if (steps[s].exp_ov) checkOutput($sformatf("bp_data_%0d", s), data_out, steps[s].exp_data);
      nextCycle();
    end

    // Asynchronous reset with two words in flight.
    applyStimulus(1'b1, 3'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 3'd3, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pre_reset_out_valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 1'b0);
    checkOutput("midreset_data_out", data_out, 32'h0);
    checkOutput("midreset_addr_err", addr_err, 1'b0);
    checkOutput("midreset_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #3 reset_n = 1'b1;
    applyStimulus(1'b1, 3'd4, 1'b1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1);
    n_out = 0;
    last_out = '0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) begin
        n_out++;
        last_out = data_out;
      end
      nextCycle();
    end
    checkOutput("after_reset_out_count", 64'(n_out), 64'd1);
    checkOutput("after_reset_first_word", last_out, 32'h14);

    // Random traffic on the 6-input instance against a queue model.
    exp_q.delete();
    for (int c = 0; c < 2000; c++) begin
      in_valid6  = 1'($urandom_range(0, 1));
      addr6      = 3'($urandom_range(0, 7));
      for (int k = 0; k < N6; k++) data_in6[k*W +: W] = $urandom;
      out_ready6 = ($urandom_range(0, 3) != 0);
      #1;
      checkOutput("rand_in_ready", in_ready6, (exp_q.size() < DEPTH) || out_ready6);
      if (out_valid6 && out_ready6) begin
        if (exp_q.size() == 0) begin
          checkOutput("rand_unexpected_output", {out_valid6, data_out6}, 64'h0);
        end else begin
          exp_item = exp_q.pop_front();
          checkOutput("rand_output", {addr_err6, data_out6}, exp_item);
        end
      end
      if (in_valid6 && in_ready6) exp_q.push_back(refSelect6(addr6, data_in6));
      nextCycle();
    end
    in_valid6 = 1'b0;
    out_ready6 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid6) begin
        if (exp_q.size() == 0) begin
          checkOutput("drain_unexpected_output", {out_valid6, data_out6}, 64'h0);
        end else begin
          exp_item = exp_q.pop_front();
          checkOutput("drain_output", {addr_err6, data_out6}, exp_item);
        end
      end
      nextCycle();
    end
    checkOutput("rand_words_lost", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
